seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 128 ++++++++++++
 tb/tb_seq_multiplier.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// One multiplier bit is consumed per cycle in CALC. The handshake is
// valid/ready on both sides: operands are taken only in IDLE, and the
// result is held in DONE until the consumer takes it.
//
// Optional feature: define MULT_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (b == 0 goes straight to DONE).
// Result values are identical with and without it; only latency changes.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // Step counter must reach WIDTH-1; one spare value keeps the width safe.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [2*WIDTH-1:0]  mcand_reg;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]    mplier_reg;  // multiplier, shifted right each step
  logic [2*WIDTH-1:0]  acc_reg;     // running partial product
  logic [CW-1:0]       cnt_reg;     // number of steps already performed

  logic [2*WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]    mplier_next;
  logic                last_step;

  // One shift-add step, and whether this step is the final one.
  always_comb begin
    acc_next    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    mplier_next = mplier_reg >> 1;
`ifdef MULT_EARLY_TERM_EN
    // No set bits remain after this step, so further steps add nothing.
    last_step   = (mplier_next == '0) || (cnt_reg == CW'(WIDTH - 1));
`else
    last_step   = (cnt_reg == CW'(WIDTH - 1));
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      product    <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            // Clear the previous result so nothing stale shows while busy.
            product    <= '0;
            in_ready   <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
            if (b == '0) begin
              // Product is trivially zero; skip CALC entirely.
              state_reg <= DONE;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
            end
`else
            state_reg  <= CALC;
            busy       <= 1'b1;
`endif
          end
        end

        CALC: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_step) begin
            state_reg <= DONE;
            product   <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end

        DONE: begin
          // Result holds until taken; in_ready rises only after leaving
          // DONE, so an accept can never coincide with this handoff.
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: an 8-bit and a 16-bit instance, directed vectors,
// expected results queued at issue time and checked by per-instance monitors.
module tb_seq_multiplier;

`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the 8-bit instance: first cycle of out_valid pops and checks,
  // later cycles of the same result check that product holds.
  exp_t        e8;
  logic        seen8 = 1'b0;
  logic [15:0] held8;
  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (!seen8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon8_unexpected: got product 0x%0h, expected no output", p8);
        end else begin
          e8 = q8.pop_front();
          check("mon8_product", {16'h0, p8}, e8.prod);
          check("mon8_latency", cyc - e8.acc_cyc + 1, e8.lat);
          $display("w8  result product=0x%04h latency=%0d", p8, cyc - e8.acc_cyc + 1);
        end
        seen8 = 1'b1;
        held8 = p8;
      end else begin
        check("mon8_hold", {16'h0, p8}, {16'h0, held8});
      end
    end else begin
      seen8 = 1'b0;
    end
  end

  // Monitor for the 16-bit instance.
  exp_t        e16;
  logic        seen16 = 1'b0;
  always @(negedge clk) begin
    if (rst_n && ov16) begin
      if (!seen16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon16_unexpected: got product 0x%0h, expected no output", p16);
        end else begin
          e16 = q16.pop_front();
          check("mon16_product", p16, e16.prod);
          check("mon16_latency", cyc - e16.acc_cyc + 1, e16.lat);
          $display("w16 result product=0x%08h latency=%0d", p16, cyc - e16.acc_cyc + 1);
        end
        seen16 = 1'b1;
      end
    end else begin
      seen16 = 1'b0;
    end
  end

  // Present one operand pair to the 8-bit instance once it is ready.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] tp,
                        input int tl, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ir8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) begin
      checks++;
      errors++;
      $display("FAIL issue8_timeout: in_ready=%0b, expected 1 within 200 cycles", ir8);
      return;
    end
    iv8 = 1'b1;
    a8  = ta;
    b8  = tb_;
    @(posedge clk);
    #1;
    if (push) q8.push_back('{{16'h0, tp}, tl, cyc});
    $display("w8  issue a=0x%02h b=0x%02h expect=0x%04h", ta, tb_, tp);
    check("accept8_in_ready", {31'h0, ir8}, 32'h0);
    iv8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_, input logic [31:0] tp,
                         input int tl);
    int n = 0;
    @(negedge clk);
    while (!ir16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir16) begin
      checks++;
      errors++;
      $display("FAIL issue16_timeout: in_ready=%0b, expected 1 within 200 cycles", ir16);
      return;
    end
    iv16 = 1'b1;
    a16  = ta;
    b16  = tb_;
    @(posedge clk);
    #1;
    q16.push_back('{tp, tl, cyc});
    $display("w16 issue a=0x%04h b=0x%04h expect=0x%08h", ta, tb_, tp);
    check("accept16_busy", {31'h0, busy16}, 32'h1);
    iv16 = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0 || ov8 || ov16) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q8.size(), q16.size());
    end
  endtask

  // Directed 8-bit vectors: a, b, product, latency fixed, latency early-term.
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat_fix;
    int          lat_et;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd1,   8'd2,   16'h0002, 9, 3},
    '{8'd4,   8'd16,  16'h0040, 9, 6},
    '{8'd64,  8'd12,  16'h0300, 9, 5},
    '{8'd9,   8'd112, 16'h03F0, 9, 8},
    '{8'd255, 8'd255, 16'hFE01, 9, 9},
    '{8'd0,   8'd255, 16'h0000, 9, 9},
    '{8'h07,  8'h01,  16'h0007, 9, 2},
    '{8'h07,  8'h10,  16'h0070, 9, 6},
    '{8'h07,  8'h00,  16'h0000, 9, 1}
  };

  initial begin
    int n;
    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready",  {31'h0, ir8},   32'h1);
    check("rst_out_valid", {31'h0, ov8},   32'h0);
    check("rst_busy",      {31'h0, busy8}, 32'h0);
    check("rst_product",   {16'h0, p8},    32'h0);
    check("rst_product16", p16,            32'h0);
    rst_n = 1'b1;

    // Main vectors, back to back (out_ready held high, also before DONE).
    foreach (vecs[i]) issue8(vecs[i].a, vecs[i].b, vecs[i].p,
                             ET ? vecs[i].lat_et : vecs[i].lat_fix, 1'b1);
    drain(100);

    // Backpressure: result held for 5 cycles while a new request is offered.
    or8 = 1'b0;
    issue8(8'd13, 8'd11, 16'h008F, ET ? 5 : 9, 1'b1);
    n = 0;
    while (!ov8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", {31'h0, ov8}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      iv8 = 1'b1;
      a8  = 8'd99;
      b8  = 8'd99;
      @(negedge clk);
      check("bp_in_ready_low", {31'h0, ir8}, 32'h0);
      check("bp_out_valid_held", {31'h0, ov8}, 32'h1);
      check("bp_product_held", {16'h0, p8}, 32'h008F);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    check("bp_released_out_valid", {31'h0, ov8}, 32'h0);
    check("bp_released_in_ready",  {31'h0, ir8}, 32'h1);
    check("bp_released_busy",      {31'h0, busy8}, 32'h0);
    repeat (12) @(negedge clk);
    check("bp_no_late_accept", {31'h0, ir8}, 32'h1);

    // Reset three cycles into CALC aborts the operation.
    issue8(8'd7, 8'd9, 16'h0000, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, ov8},   32'h0);
    check("midrst_product",   {16'h0, p8},    32'h0);
    check("midrst_in_ready",  {31'h0, ir8},   32'h1);
    check("midrst_busy",      {31'h0, busy8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'd3, 8'd5, 16'h000F, ET ? 4 : 9, 1'b1);
    drain(100);

    // 16-bit instance.
    issue16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
    issue16(16'h1234, 16'h0100, 32'h00123400, ET ? 10 : 17);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
